// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default sizing and counter-width helper shared by the UART blocks.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    localparam int DEF_CLKS_PER_BIT = 5208;
    localparam int DEF_DATA_SIZE    = 8;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: FIFO read port plus serial-side status of the UART transmitter.
interface uart_tx_fifo_drain_if
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
);
    logic                 fifo_empty;
    logic [DATA_SIZE-1:0] fifo_data;
    logic                 fifo_read;
    logic                 tx;
    logic                 busy;
    logic                 tx_done;

    modport master (output fifo_empty, fifo_data, input fifo_read, tx, busy, tx_done);
    modport slave  (input fifo_empty, fifo_data, output fifo_read, tx, busy, tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: restartable divider giving a one-cycle tick every CLKS_PER_BIT clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int W = cnt_width(CLKS_PER_BIT);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(CLKS_PER_BIT - 1));

    always_comb cnt_d = (clear || tick) ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops one FIFO byte per frame and serializes it LSB first, 8N1 by default.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input logic                 clk,
    input logic                 reset,
    uart_tx_fifo_drain_if.slave bus
);
    localparam int BW = cnt_width(DATA_SIZE);
`ifdef UART_TX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 tick, fifo_read;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Reset gates the pop so a byte is never lost to an aborted latch.
    assign fifo_read   = (state_q == IDLE) && !bus.fifo_empty && !reset;
    assign bus.fifo_read = fifo_read;
    assign bus.tx      = tx_q;
    assign bus.busy    = (state_q != IDLE) || fifo_read;
    assign bus.tx_done = (state_q == STOP) && tick;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_read),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: if (fifo_read) begin
                shift_d = bus.fifo_data;
                bit_d   = '0;
                state_d = START;
`ifdef UART_TX_PARITY_EN
                parity_d = ^bus.fifo_data;
`endif
            end
            START: if (tick) state_d = DATA;
            DATA: if (tick) begin
                if (bit_q == BW'(DATA_SIZE - 1)) state_d = AFTER_DATA;
                else begin
                    bit_d   = bit_q + BW'(1);
                    shift_d = shift_q >> 1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP: if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The line is driven from the next state so it is a clean registered output.
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
        if (state_d == PARITY) tx_d = parity_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: scoreboard bench; bytes queued into a FIFO model are expected back as UART frames.
module tb_uart_tx_fifo_drain;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0, fails = 0;

    uart_tx_fifo_drain_if #(.DATA_SIZE(8)) bus ();

    uart_tx_fifo_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:63];
    int wr = 0, rd = 0, pops = 0;
    logic [7:0] exp_q [$];

    assign bus.fifo_empty = (wr == rd);
    assign bus.fifo_data  = mem[rd[5:0]];

    always @(posedge clk) if (bus.fifo_read) begin
        rd   <= rd + 1;
        pops <= pops + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        @(posedge clk);
        #1;
        mem[wr[5:0]] = v;
        exp_q.push_back(v);
        wr++;
    endtask

    int fc = -1, frames = 0;
    int line_err, busy_err, done_err, pop_err;
    logic [NB-1:0] fbits, got;
    logic [7:0] exp_b;
    logic pend;

    always @(negedge clk) begin
        if (reset) fc = -1;
        else begin
            if (fc == FRAME + 1) begin
                chk("gap_tx", bus.tx, 1'b1);
                chk("pop_next", bus.fifo_read, pend);
                fc = -1;
            end
            if (fc >= 1) begin
                if (bus.tx !== fbits[(fc - 1) / CPB]) line_err++;
                if (bus.busy !== 1'b1) busy_err++;
                if (bus.tx_done !== (fc == FRAME)) done_err++;
                if (bus.fifo_read) pop_err++;
                if ((fc - 1) % CPB == CPB / 2) got[(fc - 1) / CPB] = bus.tx;
                if (fc == FRAME) begin
                    chk("line", line_err, 0);
                    chk("busy", busy_err, 0);
                    chk("done", done_err, 0);
                    chk("pop_mid", pop_err, 0);
                    chk("data", got[8:1], exp_b);
                    chk("frame_bits", got, fbits);
                    pend = !bus.fifo_empty;
                    frames++;
                end
                fc++;
            end else if (fc < 0 && bus.fifo_read) begin
                chk("pop_nonempty", bus.fifo_empty, 1'b0);
                chk("pop_busy", bus.busy, 1'b1);
                chk("sb_avail", exp_q.size() > 0, 1'b1);
                exp_b = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
`ifdef UART_TX_PARITY_EN
                fbits = {1'b1, ^exp_b, exp_b, 1'b0};
`else
                fbits = {1'b1, exp_b, 1'b0};
`endif
                got = '0;
                line_err = 0; busy_err = 0; done_err = 0; pop_err = 0;
                fc = 1;
            end
        end
    end

    int want = 0;
    task automatic wait_frames(input int n);
        want += n;
        for (int i = 0; i < n * (FRAME + 4) + 20 && frames < want; i++) @(posedge clk);
        chk("frames_timeout", frames, want);
    endtask

    initial begin
        int err;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_read", bus.fifo_read, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.tx_done, 1'b0);
        reset = 1'b0;

        err = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.fifo_read !== 1'b0 || bus.busy !== 1'b0) err++;
        end
        chk("idle_100", err, 0);

        push(8'hA5);
        wait_frames(1);
        chk("pops_a5", pops, 1);

        push(8'h01);
        push(8'hFF);
        push(8'h00);
        wait_frames(3);
        chk("pops_b2b", pops, 4);

        push(8'h3C);
        repeat (18) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_tx", bus.tx, 1'b1);
        chk("abort_busy", bus.busy, 1'b0);
        push(8'h5A);
        err = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.fifo_read !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) err++;
        end
        chk("rst_hold", err, 0);
        chk("pops_abort", pops, 5);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_frames(1);
        chk("pops_after_rst", pops, 6);

        push(8'h11);
        repeat (10) @(posedge clk);
        push(8'h22);
        wait_frames(2);
        chk("pops_midfill", pops, 8);

        repeat (5) @(posedge clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("fifo_drained", wr - rd, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
